ht_drain: RTL and testbench

HT_DRAIN -- requirements
Module: ht_drain

---
 rtl/ht_drain.sv | 150 +++++++++++++++
 tb/tb_ht_drain.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_drain.sv
// ht_drain: drains the parallel output of an upstream sorter as a serial
// valid/ready stream.
//
// A start pulse (the same pulse that loads the sorter) arms a latency
// countdown. When the countdown expires, the sorted array is snapshotted
// into a local buffer. The buffer is then emitted one element per
// accepted transfer. A one-cycle `over` pulse follows the last element.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      one-cycle pulse that starts a drain (honoured only when idle)
//   sorted     parallel sorter output, index elements of width bits
//   out_data   current stream element (0 whenever out_valid is low)
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
//   out_last   current element is the final one
//   over       one-cycle pulse after the final transfer
//   busy       a drain is in progress (any state but IDLE)
//   drop_err   sticky: a start arrived while busy
module ht_drain #(
   parameter int index = 32,
   parameter int width = 5,
   parameter int LAT   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [width-1:0] sorted [0:index-1],
   output logic [width-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             over,
   output logic             busy,
   output logic             drop_err
);

   localparam int unsigned N  = index;
   localparam int          IW = $clog2(index);
   localparam int          CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(index - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SEND,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    idx;
   logic [width-1:0] buf_q [0:index-1];

   logic load_cnt;
   logic dec_cnt;
   logic capture;
   logic xfer;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and output decode. All stream outputs are decoded from the
   // state, so the asynchronous reset clears them without waiting for clk.
   always_comb begin
      state_nxt = state;
      load_cnt  = 1'b0;
      dec_cnt   = 1'b0;
      capture   = 1'b0;
      xfer      = 1'b0;
      out_valid = 1'b0;
      over      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_cnt  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture   = 1'b1;
               state_nxt = SEND;
            end else begin
               dec_cnt = 1'b1;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            if (out_ready) begin
               xfer = 1'b1;
               if (idx == IDX_LAST) begin
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            over      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy     = (state != IDLE);
      out_last = (state == SEND) && (idx == IDX_LAST);
      out_data = out_valid ? buf_q[idx] : '0;
   end

   // Datapath: latency counter, element index, capture buffer, error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         idx      <= '0;
         drop_err <= 1'b0;
         for (int unsigned i = 0; i < N; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         if (load_cnt) begin
            cnt <= CNT_INIT;
         end else if (dec_cnt) begin
            cnt <= cnt - CW'(1);
         end

         if (capture) begin
            idx <= '0;
            for (int unsigned i = 0; i < N; i++) begin
               buf_q[i] <= sorted[i];
            end
         end else if (xfer) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         end

         if (start && busy) begin
            drop_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ht_drain.sv
// Testbench for ht_drain. Random and directed stimulus is checked every
// cycle against a transaction-level model. The model holds a countdown to
// the capture, a queue of captured elements still to be sent, a pending
// over pulse and the sticky drop flag.
module tb_ht_drain;

   localparam int N = 32;
   localparam int W = 5;
   localparam int L = 6;

   logic         clk;
   logic         rst;
   logic         start;
   logic         ready;
   logic [W-1:0] sorted_tb [0:N-1];
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_last;
   logic         over;
   logic         busy;
   logic         drop_err;

   int n_checks = 0;
   int n_fail   = 0;

   ht_drain #(.index(N), .width(W), .LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sorted    (sorted_tb),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (ready),
      .out_last  (out_last),
      .over      (over),
      .busy      (busy),
      .drop_err  (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   int           m_cd;       // edges left before capture, -1 when not waiting
   logic [W-1:0] m_q[$];     // captured elements not yet transferred
   bit           m_over;
   bit           m_drop;

   function automatic void model_reset();
      m_cd   = -1;
      m_q.delete();
      m_over = 1'b0;
      m_drop = 1'b0;
   endfunction

   function automatic bit model_idle();
      return (m_cd < 0) && (m_q.size() == 0) && !m_over;
   endfunction

   // One clock edge, using the inputs sampled at that edge
   function automatic void model_edge();
      bit pre_valid;
      bit pre_busy;
      pre_valid = (m_q.size() > 0);
      pre_busy  = !model_idle();
      if (start && pre_busy) m_drop = 1'b1;
      if (m_over) begin
         m_over = 1'b0;
      end else if (pre_valid) begin
         if (ready) begin
            m_q.delete(0);
            if (m_q.size() == 0) m_over = 1'b1;
         end
      end else if (m_cd == 0) begin
         for (int i = 0; i < N; i++) m_q.push_back(sorted_tb[i]);
         m_cd = -1;
      end else if (m_cd > 0) begin
         m_cd--;
      end else if (start) begin
         m_cd = L - 1;
      end
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit ev;
      ev = (m_q.size() > 0);
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("out_data",  {27'd0, out_data},  ev ? {27'd0, m_q[0]} : 32'd0);
      chk("out_last",  {31'd0, out_last},  {31'd0, (m_q.size() == 1)});
      chk("over",      {31'd0, over},      {31'd0, m_over});
      chk("busy",      {31'd0, busy},      {31'd0, !model_idle()});
      chk("drop_err",  {31'd0, drop_err},  {31'd0, m_drop});
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_reset();
      else      model_edge();
      #1;
      check_all();
   endtask

   // Run one drain. mode: 0 ready=1, 1 ready toggles, 2 random ready/data/starts.
   // act: 0 none, 1 extra start at idx 5, 2 async reset at idx 10,
   //      3 overwrite sorted right after capture.
   task automatic stream(input int mode, input int act, input int budget,
                         output int lat, output int nx, output int nov);
      bit done;
      bit fired;
      lat   = -1;
      nx    = 0;
      nov   = 0;
      done  = 1'b0;
      fired = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         case (mode)
            1: ready = ~ready;
            2: begin
               ready = 1'($urandom_range(0, 1));
               for (int i = 0; i < N; i++) sorted_tb[i] = W'($urandom);
               start = (!model_idle() && $urandom_range(0, 15) == 0);
            end
            default: ready = 1'b1;
         endcase
         if (out_valid && ready) nx++;
         tick();
         start = 1'b0;
         if (out_valid && lat < 0) lat = k;
         if (over) nov++;
         if (act == 1 && !fired && m_q.size() == N - 5) begin
            start = 1'b1;
            fired = 1'b1;
         end
         if (act == 3 && !fired && m_q.size() == N) begin
            for (int i = 0; i < N; i++) sorted_tb[i] = W'(31);
            fired = 1'b1;
         end
         if (act == 2 && m_q.size() == N - 10) begin
            #2;
            rst = 1'b0;
            #1;
            chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_async_data",  {27'd0, out_data},  32'd0);
            chk("rst_async_last",  {31'd0, out_last},  32'd0);
            chk("rst_async_busy",  {31'd0, busy},      32'd0);
            chk("rst_async_drop",  {31'd0, drop_err},  32'd0);
            model_reset();
            done = 1'b1;
            break;
         end
         if (model_idle()) begin
            done = 1'b1;
            break;
         end
      end
      chk("stream_completed", {31'd0, done}, 32'd1);
   endtask

   int lat, nx, nov;

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      for (int i = 0; i < N; i++) sorted_tb[i] = '0;
      model_reset();

      // Reset held with random inputs
      for (int c = 0; c < 3; c++) begin
         start = 1'($urandom_range(0, 1));
         ready = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) sorted_tb[i] = W'($urandom);
         tick();
      end
      start = 1'b0;
      ready = 1'b1;
      rst   = 1'b1;
      for (int i = 0; i < N; i++) sorted_tb[i] = W'(i);
      tick();

      // Full-speed stream of 0..31
      stream(0, 0, 200, lat, nx, nov);
      chk("full_latency", lat, L);
      chk("full_xfers",   nx,  N);
      chk("full_over",    nov, 1);
      tick();

      // Backpressure with ready toggling
      for (int i = 0; i < N; i++) sorted_tb[i] = W'($urandom);
      ready = 1'b0;
      stream(1, 0, 300, lat, nx, nov);
      chk("bp_latency", lat, L);
      chk("bp_xfers",   nx,  N);
      chk("bp_over",    nov, 1);
      tick();

      // Start while busy, at idx 5
      for (int i = 0; i < N; i++) sorted_tb[i] = W'(i);
      stream(0, 1, 200, lat, nx, nov);
      chk("busy_xfers",  nx,  N);
      chk("busy_over",   nov, 1);
      tick();
      chk("drop_sticky", {31'd0, drop_err}, 32'd1);

      // Reset in the middle of a stream, then restart on the release edge
      for (int i = 0; i < N; i++) sorted_tb[i] = W'($urandom);
      stream(0, 2, 200, lat, nx, nov);
      chk("rst_no_over", nov, 0);
      tick();
      tick();
      rst = 1'b1;
      stream(0, 0, 200, lat, nx, nov);
      chk("restart_latency", lat, L);
      chk("restart_xfers",   nx,  N);
      tick();

      // Sorted overwritten after capture
      for (int i = 0; i < N; i++) sorted_tb[i] = W'(i);
      stream(0, 3, 200, lat, nx, nov);
      chk("iso_xfers", nx, N);
      tick();

      // Random traffic
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) sorted_tb[i] = W'($urandom);
         stream(2, 0, 400, lat, nx, nov);
         chk("rand_over", nov, 1);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
